// File: rtl/dot_layer_seq_pkg.sv
// rtl/dot_layer_seq_pkg.sv - shared state encoding and widths for the dot-layer sequencer
package dot_layer_seq_pkg;

    localparam int CS_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_RUN    = 3'd2,
        ST_WAIT_V = 3'd3,
        ST_CAP    = 3'd4,
        ST_OUT    = 3'd5
    } state_e;

    function automatic int timer_width(input int timeout);
        return $clog2(timeout) + 1;
    endfunction

endpackage

// File: rtl/dot_layer_seq_timer.sv
// rtl/dot_layer_seq_timer.sv - loadable down-counter with expire flag for the WAIT_V timeout
module dot_seq_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    input  logic         en_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/dot_layer_seq.sv
// rtl/dot_layer_seq.sv - per-pixel load/cs sequencer for one layer of dot channels
module dot_layer_seq
    import dot_layer_seq_pkg::*;
#(
    parameter int N_PIX   = 196,
    parameter int CS_LAST = 11,
    parameter int N_CH    = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             load,
    output logic [CS_W-1:0]  cs,
    input  logic [N_CH-1:0]  ch_valid,
    output logic             cap,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      pix_idx,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int TMR_W = timer_width(TIMEOUT);

    state_e          state_q, state_d;
    logic [CS_W-1:0] cs_q, cs_d;
    logic [15:0]     pix_q, pix_d;
    logic            err_q, err_d;
    logic            done_q, done_d;
    logic            tmr_ld, tmr_en, tmr_expired;
    logic            cs_at_last, last_pix, all_valid;

    assign cs_at_last = (cs_q == CS_W'(CS_LAST));
    assign last_pix   = (pix_q == 16'(N_PIX - 1));
    assign all_valid  = &ch_valid;
    // Timer is armed on the RUN->WAIT_V edge so WAIT_V cycle k sees TIMEOUT-1-k.
    assign tmr_ld     = (state_q == ST_RUN) && cs_at_last;
    assign tmr_en     = (state_q == ST_WAIT_V);

    dot_seq_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .ld_i      (tmr_ld),
        .ld_val_i  (TMR_W'(TIMEOUT - 1)),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cs_q    <= '0;
            pix_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cs_q    <= cs_d;
            pix_q   <= pix_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cs_d    = cs_q;
        pix_d   = pix_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACCEPT;
                    pix_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_ACCEPT: begin
                if (in_valid) begin
                    state_d = ST_RUN;
                    cs_d    = '0;
                end
            end
            ST_RUN: begin
                if (cs_at_last) begin
                    state_d = ST_WAIT_V;
                end else begin
                    cs_d = cs_q + 1'b1;
                end
            end
            ST_WAIT_V: begin
                // A full valid on the expiry cycle still counts as a good result.
                if (all_valid) begin
                    state_d = ST_CAP;
                    cs_d    = '0;
                end else if (tmr_expired) begin
                    state_d = ST_CAP;
                    cs_d    = '0;
                    err_d   = 1'b1;
                end
            end
            ST_CAP: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (last_pix) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ACCEPT;
                        pix_d   = pix_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_ACCEPT);
        load      = (state_q == ST_RUN) || (state_q == ST_WAIT_V);
        cap       = (state_q == ST_CAP);
        out_valid = (state_q == ST_OUT);
        busy      = (state_q != ST_IDLE);
        cs        = cs_q;
        pix_idx   = pix_q;
        err       = err_q;
        done      = done_q;
    end

endmodule

// File: tb/tb_dot_layer_seq.sv
// tb/tb_dot_layer_seq.sv - scoreboard bench for the dot-layer sequencer
module tb_dot_layer_seq;

    localparam int N_PIX   = 2;
    localparam int CS_LAST = 11;
    localparam int N_CH    = 16;
    localparam int TIMEOUT = 64;

    logic              clk;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              load;
    logic [3:0]        cs;
    logic [N_CH-1:0]   ch_valid;
    logic              cap;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       pix_idx;
    logic              busy;
    logic              done;
    logic              err;

    typedef struct {
        int   pix;
        logic err;
        int   lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    dot_layer_seq #(
        .N_PIX   (N_PIX),
        .CS_LAST (CS_LAST),
        .N_CH    (N_CH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .load      (load),
        .cs        (cs),
        .ch_valid  (ch_valid),
        .cap       (cap),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pix_idx   (pix_idx),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        check("rst_load", int'(load), 0);
        check("rst_cs", int'(cs), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_cap", int'(cap), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_pix_idx", int'(pix_idx), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // mode 0: all channels valid; 1: bit 3 five cycles late; 2: stuck at 0xFFFE
    task automatic do_pixel(input int exp_pix, input int acc_delay, input int mode,
                            input int bp, input logic exp_err);
        int n;
        int lat;
        lat = (mode == 0) ? 14 : (mode == 1) ? 19 : 77;
        out_ready = (bp == 0);
        n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("accept_wait", int'(in_ready), 1);
        for (int i = 0; i < acc_delay; i++) begin
            check("stall_load", int'(load), 0);
            check("stall_cs", int'(cs), 0);
            check("stall_in_ready", int'(in_ready), 1);
            start = (i == 3);
            tick();
        end
        start = 1'b0;
        check("pix_at_accept", int'(pix_idx), exp_pix);
        sb.push_back('{pix: exp_pix, err: exp_err, lat: lat});
        in_valid = 1'b1;
        ch_valid = (mode == 1) ? 16'hFFF7 : (mode == 2) ? 16'hFFFE : 16'hFFFF;
        tick();
        in_valid = 1'b0;
        if (mode == 1) begin
            repeat (17) tick();
            ch_valid = 16'hFFFF;
        end
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        check("out_valid_wait", int'(out_valid), 1);
        ch_valid = '0;
        for (int i = 0; i < bp; i++) begin
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_load", int'(load), 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
    endtask

    // Monitor: pops the scoreboard on cap / output handshake.
    initial begin : monitor
        int   cyc;
        int   acc_cyc;
        int   load_n;
        logic exp_done;
        exp_t e;
        cyc = 0;
        acc_cyc = 0;
        load_n = 0;
        exp_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                load_n = 0;
                exp_done = 1'b0;
            end else begin
                if (done || exp_done) check("done_pulse", int'(done), int'(exp_done));
                exp_done = 1'b0;
                if (in_valid && in_ready) begin
                    acc_cyc = cyc;
                    load_n = 0;
                end
                if (load) begin
                    check("cs_seq", int'(cs), (load_n < CS_LAST) ? load_n : CS_LAST);
                    load_n++;
                end
                if (cap) begin
                    if (sb.size() == 0) begin
                        check("cap_unexpected", 1, 0);
                    end else begin
                        check("cap_latency", cyc - acc_cyc, sb[0].lat);
                        check("load_cycles", load_n, sb[0].lat - 1);
                        check("cap_cs_zero", int'(cs), 0);
                    end
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("out_unexpected", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("out_pix_idx", int'(pix_idx), e.pix);
                        check("out_err", int'(err), int'(e.err));
                        exp_done = (e.pix == N_PIX - 1);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        ch_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;

        // Nominal two-pixel run
        pulse_start();
        check("busy_after_start", int'(busy), 1);
        do_pixel(0, 0, 0, 0, 1'b0);
        do_pixel(1, 0, 0, 0, 1'b0);
        check("idle_after_run", int'(busy), 0);

        // Staggered valid with backpressure, then a stalled accept with start pulses
        pulse_start();
        do_pixel(0, 0, 1, 7, 1'b0);
        do_pixel(1, 10, 0, 0, 1'b0);

        // Timeout sets a sticky err that survives to the next start
        pulse_start();
        do_pixel(0, 0, 2, 0, 1'b1);
        do_pixel(1, 0, 0, 0, 1'b1);
        check("err_sticky_idle", int'(err), 1);
        pulse_start();
        check("err_cleared_by_start", int'(err), 0);

        // Reset during RUN of pixel 1
        do_pixel(0, 0, 0, 0, 1'b0);
        in_valid = 1'b1;
        ch_valid = 16'hFFFF;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check("pre_rst_cs", int'(cs), 5);
        check("pre_rst_pix", int'(pix_idx), 1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals();
        sb.delete();
        ch_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("post_rst_idle", int'(busy), 0);
        pulse_start();
        do_pixel(0, 0, 0, 0, 1'b0);
        do_pixel(1, 0, 0, 0, 1'b0);

        repeat (4) tick();
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dot_layer_seq.md
Name: dot_layer_seq

Overview:
Sequencer for one layer of dot-channel instances that share a common feature bus and chip-select. Per output pixel it:
- accepts a feature window from upstream;
- drives load and steps cs through the weight chunks;
- waits for all channels to report valid;
- presents the result to downstream.

It sits between the feature-window buffer and the layer's dot-channel array and replaces ad-hoc load/cs generation in the layer top.

Parameters:
N_PIX, 196, output pixels per layer run (1..65535)
CS_LAST, 11, final cs value; cs steps 0..CS_LAST
N_CH, 16, dot-channel instances driven (width of ch_valid)
TIMEOUT, 64, cycles allowed in WAIT_V before error

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse, begin layer run; ignored unless IDLE
in_valid  in  1  upstream feature window valid
in_ready  out  1  window accepted this cycle when in_valid&in_ready
load  out  1  level to all dot channels; high for the whole compute of one pixel
cs  out  4  weight chunk select to all dot channels
ch_valid  in  N_CH  per-channel valid
cap  out  1  one-cycle strobe: channel outputs must be registered by layer top
out_valid  out  1  result available downstream
out_ready  in  1  downstream accepts when out_valid&out_ready
pix_idx  out  16  index of pixel being processed / presented
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after last pixel handed off
err  out  1  sticky timeout flag, cleared by rst or start

Behaviour:
- Reset (async assert, sync release): state IDLE; load=0, cs=0, in_ready=0, cap=0, out_valid=0, pix_idx=0, busy=0, done=0, err=0.
- States and transitions:
  - IDLE: start -> ACCEPT, pix_idx=0, err=0.
  - ACCEPT: in_ready=1. On in_valid -> RUN, load=1, cs=0.
  - RUN: load=1; cs increments each cycle. When cs==CS_LAST -> WAIT_V, timer cleared; cs holds CS_LAST.
  - WAIT_V: load=1, cs=CS_LAST; timer increments. When &ch_valid -> CAP. If timer reaches TIMEOUT-1 first -> err=1, go to CAP anyway (result marked bad via err).
  - CAP: cap=1 for exactly one cycle; load=0, cs=0 -> OUT.
  - OUT: out_valid=1 until out_ready.
    - On handshake, if pix_idx==N_PIX-1 -> IDLE with done=1.
    - Otherwise pix_idx++ -> ACCEPT.
- load spacing: load is low for at least two cycles (CAP, OUT) between pixels, guaranteeing a clean rising edge per pixel for channel re-init.
- First-pixel latency: accept at cycle t -> load rises t+1 -> cs reaches CS_LAST at t+1+CS_LAST -> earliest cap at t+3+CS_LAST (ch_valid seen first cycle of WAIT_V).
- Upstream backpressure: in_ready only in ACCEPT, so the feature bus is held stable by upstream through RUN/WAIT_V (upstream must not change window until next accept).
- Ignored inputs: start while busy is ignored. ch_valid outside WAIT_V is ignored.
- Partial valid: if only some bits of ch_valid are set, wait.
- rst mid-run: immediate return to reset values; no done pulse.
- out_ready held high: OUT lasts one cycle.
- N_PIX=1: single pass; done one cycle after the OUT handshake.
- Counters: pix_idx 16-bit, no wrap (bounded by N_PIX). Timer width clog2(TIMEOUT)+1.

Decomposition:
- Shared include: state encodings (3-bit localparams IDLE, ACCEPT, RUN, WAIT_V, CAP, OUT) and the cs width (4); use the existing data_len include.
- Natural sub-module: dot_seq_timer (loadable down-counter with expire flag) for the WAIT_V timeout.
- Everything else stays in one FSM module.

Test Plan:
- Nominal, N_PIX=2, CS_LAST=11, ch_valid all-ones 1 cycle into WAIT_V, out_ready=1:
  - cs sequence 0..11 per pixel; load high for 13 cycles per pixel;
  - cap at accept+14;
  - done one cycle after second out handshake; pix_idx 0 then 1.
- Staggered ch_valid (bit 3 late by 5 cycles) -> cap only after all bits high; err=0.
- ch_valid stuck at 0xFFFE, TIMEOUT=64 -> err=1 after 64 WAIT_V cycles, cap asserted, flow continues; err persists until next start.
- Backpressure: out_ready low 7 cycles -> out_valid held, in_ready=0, load=0 throughout; resumes on handshake.
- in_valid low 10 cycles in ACCEPT -> load stays 0, cs=0; start pulses while busy ignored.
- rst asserted during RUN (cs=5) -> all outputs to reset values asynchronously; new start runs full N_PIX from pix_idx=0.
